// File: rtl/axis_pkt_sink_if.sv
// axis_pkt_sink_if: AXI4-Stream beat bus between a packet master and the sink
interface axis_pkt_sink_if #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 3
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;
    logic [DATA_BYTES-1:0] TSTRB;
    logic [USER_WIDTH-1:0] TUSER;
    modport master (output TDATA, TVALID, TLAST, TSTRB, TUSER, input TREADY);
    modport slave (input TDATA, TVALID, TLAST, TSTRB, TUSER, output TREADY);
endinterface

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI4-Stream sink with show-ahead beat FIFO and per-packet framing summary
module axis_pkt_sink #(
    parameter int DATA_WIDTH = 128,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    axis_pkt_sink_if.slave                  axis,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [DATA_BYTES-1:0]           rd_strb,
    output logic                            rd_last,
    output logic [USER_WIDTH-1:0]           rd_user,
    output logic                            pkt_done,
    output logic [CNT_WIDTH-1:0]            pkt_bytes,
    output logic [CNT_WIDTH-1:0]            pkt_beats,
    output logic [USER_WIDTH-1:0]           pkt_user,
    output logic                            pkt_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = AW + 1;
    localparam int PW  = $clog2(DATA_BYTES + 1);
    localparam int EW  = DATA_WIDTH + DATA_BYTES + USER_WIDTH + 1;
    typedef enum logic {IDLE, IN_PKT} state_t;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [FCW-1:0]        count, count_next;
    logic                  ready_q, push, pop;
    state_t                state;
    logic [CNT_WIDTH-1:0]  acc_bytes, acc_beats, byte_base, beat_base, bytes_new, beats_new;
    logic [USER_WIDTH-1:0] first_user, user_new;
    logic                  acc_err, first, contig, beat_err, err_new;
    logic [PW-1:0]         pc;
    logic [CNT_WIDTH:0]    byte_sum, beat_sum;
    // TREADY is a pure register so no combinational path reaches it from TVALID or rd_ready
    assign axis.TREADY = ready_q;
    assign push        = axis.TVALID & ready_q;
    assign rd_valid    = count != '0;
    assign pop         = rd_valid & rd_ready;
    assign count_next  = count + FCW'(push) - FCW'(pop);
    assign fifo_count  = count;
    assign {rd_last, rd_user, rd_strb, rd_data} = rd_valid ? mem[rd_ptr] : '0;
    always_comb begin
        pc = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            pc = pc + PW'(axis.TSTRB[i]);
    end
    always_comb begin
        first     = state == IDLE;
        contig    = axis.TSTRB != '0 && (axis.TSTRB & (axis.TSTRB + DATA_BYTES'(1))) == '0;
        beat_err  = !contig | (!axis.TLAST & axis.TSTRB != '1) | (!first & axis.TUSER != first_user);
        byte_base = first ? '0 : acc_bytes;
        beat_base = first ? '0 : acc_beats;
        byte_sum  = {1'b0, byte_base} + (CNT_WIDTH + 1)'(pc);
        beat_sum  = {1'b0, beat_base} + (CNT_WIDTH + 1)'(1);
        bytes_new = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
        beats_new = beat_sum[CNT_WIDTH] ? '1 : beat_sum[CNT_WIDTH-1:0];
        user_new  = first ? axis.TUSER : first_user;
        err_new   = (!first & acc_err) | beat_err | byte_sum[CNT_WIDTH] | beat_sum[CNT_WIDTH];
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {axis.TLAST, axis.TUSER, axis.TSTRB, axis.TDATA};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            state      <= IDLE;
            acc_bytes  <= '0;
            acc_beats  <= '0;
            first_user <= '0;
            acc_err    <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_bytes  <= '0;
            pkt_beats  <= '0;
            pkt_user   <= '0;
            pkt_err    <= 1'b0;
        end else begin
            count    <= count_next;
            ready_q  <= count_next != FCW'(FIFO_DEPTH);
            pkt_done <= push & axis.TLAST;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && axis.TLAST) begin
                state     <= IDLE;
                pkt_bytes <= bytes_new;
                pkt_beats <= beats_new;
                pkt_user  <= user_new;
                pkt_err   <= err_new;
            end else if (push) begin
                state      <= IN_PKT;
                acc_bytes  <= bytes_new;
                acc_beats  <= beats_new;
                first_user <= user_new;
                acc_err    <= err_new;
            end
        end
    end
endmodule
